// File: rtl/sr_cmd_pkg.sv
// Shared types and width helpers for the SR command conditioner.
package sr_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE_S = 2'd1,
      PULSE_R = 2'd2,
      GAP     = 2'd3
   } sr_cmd_state_t;

   // Bits needed to hold a count of 0..max_count, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sr_debounce.sv
// One request channel: 2-flop synchronizer, persistence debounce and
// single-cycle rising-edge request.
module sr_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise_c
);
   import sr_cmd_pkg::*;

   localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             deb;
   logic             deb_q;
   logic [CNT_W-1:0] cnt;

   // Counter runs only while the synchronized level disagrees with the accepted one.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         deb   <= 1'b0;
         deb_q <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_q <= deb;
         if (sync2 == deb) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            deb <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign rise_c = deb & ~deb_q;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Turns two bouncy asynchronous request lines into clean, mutually exclusive
// s / r command pulses with a guaranteed idle gap between pulses.
module sr_cmd_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned PULSE_CYCLES    = 1,
   parameter int unsigned GAP_CYCLES      = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic set_raw,
   input  logic reset_raw,
   output logic s,
   output logic r,
   output logic busy,
   output logic conflict
);
   import sr_cmd_pkg::*;

   localparam int unsigned CNT_W = cnt_width(max2(PULSE_CYCLES, GAP_CYCLES));
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   sr_cmd_state_t   state;
   logic [CNT_W-1:0] cnt;
   logic            pend_s;
   logic            pend_r;
   logic            set_req_c;
   logic            reset_req_c;
   logic            any_s_c;
   logic            any_r_c;
   logic            serve_c;

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
      .clk    (clk),
      .rst    (rst),
      .raw    (set_raw),
      .rise_c (set_req_c)
   );

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_reset (
      .clk    (clk),
      .rst    (rst),
      .raw    (reset_raw),
      .rise_c (reset_req_c)
   );

   // Decision point: idle, or the final busy cycle (end of gap, or end of pulse when there is no gap).
   always_comb begin
      any_s_c = pend_s | set_req_c;
      any_r_c = pend_r | reset_req_c;
      serve_c = 1'b0;
      case (state)
         IDLE:             serve_c = 1'b1;
         PULSE_S, PULSE_R: serve_c = (GAP_CYCLES == 0) && (cnt == PULSE_LAST);
         GAP:              serve_c = (cnt == GAP_LAST);
         default:          serve_c = 1'b1;
      endcase
   end

   // FSM, pulse/gap timer, pending flags and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         pend_s   <= 1'b0;
         pend_r   <= 1'b0;
         s        <= 1'b0;
         r        <= 1'b0;
         busy     <= 1'b0;
         conflict <= 1'b0;
      end else begin
         conflict <= 1'b0;
         if (serve_c) begin
            cnt    <= '0;
            pend_s <= 1'b0;
            pend_r <= 1'b0;
            if (any_s_c && any_r_c) begin
               state    <= IDLE;
               s        <= 1'b0;
               r        <= 1'b0;
               busy     <= 1'b0;
               conflict <= 1'b1;
            end else if (any_s_c) begin
               state <= PULSE_S;
               s     <= 1'b1;
               r     <= 1'b0;
               busy  <= 1'b1;
            end else if (any_r_c) begin
               state <= PULSE_R;
               s     <= 1'b0;
               r     <= 1'b1;
               busy  <= 1'b1;
            end else begin
               state <= IDLE;
               s     <= 1'b0;
               r     <= 1'b0;
               busy  <= 1'b0;
            end
         end else begin
            pend_s <= any_s_c;
            pend_r <= any_r_c;
            if ((state == PULSE_S || state == PULSE_R) && cnt == PULSE_LAST) begin
               state <= GAP;
               s     <= 1'b0;
               r     <= 1'b0;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule
